// File: rtl/seq_mult_8bit_pkg.sv
// ============================================================================
// mult_pkg : shared types and sizing for the sequential 8x8 multiplier
// Revision : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage : mult_pkg

`default_nettype wire

// File: rtl/seq_mult_8bit_if.sv
// ============================================================================
// seq_mult_8bit_if : operand/product handshake bundle for seq_mult_8bit
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface seq_mult_8bit_if
  import mult_pkg::*;
();

  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_a;
  logic [WIDTH-1:0]   i_b;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_prod;
  logic               o_busy;

  // The multiplier side.
  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_prod, o_busy
  );

  // The operand producer / product consumer side.
  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_prod, o_busy
  );

endinterface : seq_mult_8bit_if

`default_nettype wire

// File: rtl/seq_mult_8bit_adder.sv
// ============================================================================
// adder_8bit : 8-bit ripple adder with carry-out and signed overflow flag
// Revision   : 1.0
// ============================================================================
`default_nettype none

module adder_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_carry,
  output logic       o_ovf
);

  logic [8:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
  assign o_sum   = w_full[7:0];
  assign o_carry = w_full[8];
  // Two's-complement overflow: like-signed operands producing an opposite sign.
  assign o_ovf   = (i_a[7] == i_b[7]) && (w_full[7] != i_a[7]);

endmodule : adder_8bit

`default_nettype wire

// File: rtl/seq_mult_8bit.sv
// ============================================================================
// seq_mult_8bit : unsigned 8x8->16 shift-add multiplier, one bit per cycle
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seq_mult_8bit
  import mult_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  seq_mult_8bit_if.slave bus
);

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_unused_ovf;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign w_addend = mq_q[0] ? mcand_q : '0;

  adder_8bit u_adder (
    .i_a     (acc_hi_q),
    .i_b     (w_addend),
    .i_cin   (1'b0),
    .o_sum   (w_sum),
    .o_carry (w_carry),
    .o_ovf   (w_unused_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      mq_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      mq_q     <= mq_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    mq_d     = mq_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          mcand_d  = bus.i_a;
          mq_d     = bus.i_b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry enters the MSB while the consumed multiplier bit falls off the bottom.
        {acc_hi_d, mq_d} = {w_carry, w_sum, mq_q[WIDTH-1:1]};
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_busy  = (state_q == CALC);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_prod  = (state_q == DONE) ? {acc_hi_q, mq_q} : '0;

endmodule : seq_mult_8bit

`default_nettype wire

// File: tb/tb_seq_mult_8bit.sv
// ============================================================================
// tb_seq_mult_8bit : vector table, directed corner cases and random products
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_seq_mult_8bit;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  seq_mult_8bit_if bus ();

  seq_mult_8bit dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    bit          scramble;
    bit          want_carry;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts at a falling edge with the block idle; ends at a falling edge back in idle.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input bit scramble, input bit want_carry,
                         input logic [15:0] exp, input string tag);
    int  n;
    int  busy;
    bit  carry;
    bit  hold_ok;
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    if (!scramble) bus.i_valid = 1'b0;
    n = 0; busy = 0; carry = 1'b0;
    while (bus.o_valid !== 1'b1 && n < 40) begin
      if (bus.o_busy === 1'b1) busy++;
      if (bus.o_busy === 1'b1 && dut.w_carry === 1'b1) carry = 1'b1;
      if (scramble) begin
        bus.i_a = 8'($urandom);
        bus.i_b = 8'($urandom);
      end
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
    end
    check({tag, " latency"}, n, 8);
    check({tag, " busy_cycles"}, busy, 8);
    check({tag, " prod"}, {16'h0, bus.o_prod}, {16'h0, exp});
    check({tag, " ready_in_done"}, {31'h0, bus.o_ready}, 0);
    if (want_carry) check({tag, " carry_seen"}, {31'h0, carry}, 1);
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge i_clk);
        @(negedge i_clk);
        if (bus.o_valid !== 1'b1 || bus.o_prod !== exp ||
            bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0) hold_ok = 1'b0;
      end
      check({tag, " hold_stable"}, {31'h0, hold_ok}, 1);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    check({tag, " ready_after"}, {31'h0, bus.o_ready}, 1);
    check({tag, " valid_after"}, {31'h0, bus.o_valid}, 0);
  endtask

  initial begin
    int          n_valid;
    logic [7:0]  ra;
    logic [7:0]  rb;

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;

    vecs[0] = '{8'd13,  8'd11,  0,  1'b0, 1'b0, 16'h008F};
    vecs[1] = '{8'd255, 8'd255, 0,  1'b0, 1'b1, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 0,  1'b0, 1'b0, 16'h0000};
    vecs[3] = '{8'd77,  8'd0,   0,  1'b0, 1'b0, 16'h0000};
    vecs[4] = '{8'd201, 8'd99,  20, 1'b0, 1'b0, 16'h4DBB};
    vecs[5] = '{8'd37,  8'd150, 5,  1'b1, 1'b0, 16'h15AE};
    vecs[6] = '{8'd128, 8'd2,   0,  1'b0, 1'b0, 16'h0100};
    vecs[7] = '{8'd1,   8'd255, 0,  1'b0, 1'b0, 16'h00FF};

    #12;
    check("reset ready", {31'h0, bus.o_ready}, 1);
    check("reset valid", {31'h0, bus.o_valid}, 0);
    check("reset busy",  {31'h0, bus.o_busy},  0);
    check("reset prod",  {16'h0, bus.o_prod},  0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].scramble,
              vecs[i].want_carry, vecs[i].prod, $sformatf("vec%0d", i));
    end

    // Abort mid-calculation with an asynchronous reset.
    bus.i_valid = 1'b1;
    bus.i_a     = 8'd200;
    bus.i_b     = 8'd100;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    repeat (4) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("abort ready", {31'h0, bus.o_ready}, 1);
    check("abort valid", {31'h0, bus.o_valid}, 0);
    check("abort busy",  {31'h0, bus.o_busy},  0);
    check("abort prod",  {16'h0, bus.o_prod},  0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (bus.o_valid === 1'b1) n_valid++;
    end
    check("abort no_valid", n_valid, 0);
    run_txn(8'd6, 8'd7, 0, 1'b0, 1'b0, 16'h002A, "post_abort");

    // Random operands against plain integer multiplication.
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_txn(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), 1'b0,
              16'(int'(ra) * int'(rb)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_mult_8bit

`default_nettype wire
